// File: rtl/seg_capture.sv
// Captures a two-digit multiplexed 7-segment display into a byte; 3 cycles capture-to-valid, no backpressure.
// Optional SEG_CAPTURE_ERR_EN: illegal glyphs pulse err and void the phase instead of decoding to 0.
module seg_capture #(
   parameter int STABLE  = 4,
   parameter int TIMEOUT = 1024
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] seg_in,
   input  logic       dsel_in,
   output logic [7:0] value,
   output logic       valid,
   output logic       locked,
   output logic       err
);

   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {WAIT_EDGE, SETTLE, HOLD} state_t;

   logic [6:0]    seg_s1, seg_s2, seg_prev;
   logic          dsel_s1, dsel_s2, dsel_q;
   state_t        state, state_nx;
   logic          phase, phase_nx;
   logic [7:0]    stab_cnt, stab_nx;
   logic [TW-1:0] to_cnt;
   logic [6:0]    up_seg, lo_seg;
   logic          pending;
   logic          pair_hit, pair_done;
   logic [7:0]    pair_val;
   logic [3:0]    up_nib, lo_nib;
   logic          dsel_edge, seg_same, to_fire;
   logic          cap_up, cap_lo, cap_err, abandon;

   function automatic logic [3:0] decode(input logic [6:0] s);
      case (s)
         7'h3F:   decode = 4'h0;
         7'h06:   decode = 4'h1;
         7'h5B:   decode = 4'h2;
         7'h4F:   decode = 4'h3;
         7'h66:   decode = 4'h4;
         7'h6D:   decode = 4'h5;
         7'h7D:   decode = 4'h6;
         7'h07:   decode = 4'h7;
         7'h7F:   decode = 4'h8;
         7'h6F:   decode = 4'h9;
         7'h77:   decode = 4'hA;
         7'h7C:   decode = 4'hB;
         7'h39:   decode = 4'hC;
         7'h5E:   decode = 4'hD;
         7'h79:   decode = 4'hE;
         7'h71:   decode = 4'hF;
         default: decode = 4'h0;
      endcase
   endfunction

`ifdef SEG_CAPTURE_ERR_EN
   function automatic logic seg_legal(input logic [6:0] s);
      case (s)
         7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
         7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71: seg_legal = 1'b1;
         default: seg_legal = 1'b0;
      endcase
   endfunction
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_s1   <= '0;
         seg_s2   <= '0;
         seg_prev <= '0;
         dsel_s1  <= 1'b0;
         dsel_s2  <= 1'b0;
         dsel_q   <= 1'b0;
      end else begin
         seg_s1   <= seg_in;
         seg_s2   <= seg_s1;
         seg_prev <= seg_s2;
         dsel_s1  <= dsel_in;
         dsel_s2  <= dsel_s1;
         dsel_q   <= dsel_s2;
      end
   end

   assign dsel_edge = dsel_s2 ^ dsel_q;
   assign seg_same  = (seg_s2 == seg_prev);
   // Fires only on the step into saturation; a coincident dsel edge suppresses it.
   assign to_fire   = !dsel_edge && (to_cnt == TW'(TIMEOUT - 1));

   always_comb begin
      state_nx = state;
      phase_nx = phase;
      stab_nx  = stab_cnt;
      cap_up   = 1'b0;
      cap_lo   = 1'b0;
      cap_err  = 1'b0;
      abandon  = 1'b0;
      if (dsel_edge) begin
         state_nx = SETTLE;
         phase_nx = dsel_s2;
         stab_nx  = 8'd0;
         abandon  = (state == SETTLE);
      end else if (to_fire) begin
         state_nx = WAIT_EDGE;
         stab_nx  = 8'd0;
      end else begin
         case (state)
            SETTLE: begin
               if (!seg_same) begin
                  stab_nx = 8'd0;
               end else if (stab_cnt == 8'(STABLE - 1)) begin
                  state_nx = HOLD;
`ifdef SEG_CAPTURE_ERR_EN
                  if (!seg_legal(seg_s2)) begin
                     cap_err = 1'b1;
                  end else if (phase) begin
                     cap_up = 1'b1;
                  end else begin
                     cap_lo = 1'b1;
                  end
`else
                  if (phase) begin
                     cap_up = 1'b1;
                  end else begin
                     cap_lo = 1'b1;
                  end
`endif
               end else begin
                  stab_nx = stab_cnt + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= WAIT_EDGE;
         phase    <= 1'b0;
         stab_cnt <= 8'd0;
      end else begin
         state    <= state_nx;
         phase    <= phase_nx;
         stab_cnt <= stab_nx;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         to_cnt <= '0;
      end else if (dsel_edge) begin
         to_cnt <= '0;
      end else if (to_cnt != TW'(TIMEOUT)) begin
         to_cnt <= to_cnt + TW'(1);
      end
   end

   // A pair needs an upper capture directly followed by a lower capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         up_seg   <= '0;
         lo_seg   <= '0;
         pending  <= 1'b0;
         pair_hit <= 1'b0;
      end else begin
         if (cap_up) up_seg <= seg_s2;
         if (cap_lo) lo_seg <= seg_s2;
         pair_hit <= cap_lo && pending;
         if (to_fire || abandon || cap_err) begin
            pending <= 1'b0;
         end else if (cap_up) begin
            pending <= 1'b1;
         end else if (cap_lo) begin
            pending <= 1'b0;
         end
      end
   end

   assign up_nib = decode(up_seg);
   assign lo_nib = decode(lo_seg);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pair_done <= 1'b0;
         pair_val  <= 8'h00;
         value     <= 8'h00;
         valid     <= 1'b0;
         locked    <= 1'b0;
      end else begin
         pair_done <= pair_hit;
         if (pair_hit) pair_val <= {up_nib, lo_nib};
         valid <= pair_done;
         if (pair_done) value <= pair_val;
         if (pair_done) begin
            locked <= 1'b1;
         end else if (to_fire) begin
            locked <= 1'b0;
         end
      end
   end

`ifdef SEG_CAPTURE_ERR_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err <= 1'b0;
      end else begin
         err <= cap_err;
      end
   end
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_seg_capture.sv
// Directed bench for seg_capture (STABLE=4, TIMEOUT=64) with an expected-value queue scoreboard.
module tb_seg_capture;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] seg_in;
   logic       dsel_in;
   logic [7:0] value;
   logic       valid;
   logic       locked;
   logic       err;

   int n_assert  = 0;
   int n_fail    = 0;
   int err_cnt   = 0;
   int valid_cnt = 0;
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   seg_capture #(.STABLE(4), .TIMEOUT(64)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .seg_in  (seg_in),
      .dsel_in (dsel_in),
      .value   (value),
      .valid   (valid),
      .locked  (locked),
      .err     (err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic d, input logic [6:0] s, input int n);
      dsel_in = d;
      seg_in  = s;
      wait_cyc(n);
   endtask

   always @(negedge clk) begin
      if (valid === 1'b1) begin
         logic [7:0] e;
         valid_cnt++;
         n_assert++;
         assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL unexpected_valid: observed value %0h, expected no valid", value);
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("pair_value", 32'(value), 32'(e));
         end
         chk("locked_with_valid", 32'(locked), 32'd1);
      end
      if (err === 1'b1) err_cnt++;
   end

   initial begin
      int v0;
      int e0;
      rst_n   = 1'b0;
      seg_in  = 7'h00;
      dsel_in = 1'b0;
      wait_cyc(3);
      chk("rst_value", 32'(value), 32'h00);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_locked", 32'(locked), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      rst_n = 1'b1;
      wait_cyc(2);

      // Pair 1/2, then dsel held for 70 cycles to exercise the timeout.
      drive(1'b1, 7'h06, 20);
      exp_q.push_back(8'h12);
      drive(1'b0, 7'h5B, 20);
      chk("pair12_value", 32'(value), 32'h12);
      chk("pair12_locked", 32'(locked), 32'd1);
      chk("pair12_count", 32'(valid_cnt), 32'd1);
      // dsel change is seen two flops later; 64 cycles after that edge locked drops.
      wait_cyc(46);
      chk("timeout_not_yet", 32'(locked), 32'd1);
      wait_cyc(1);
      chk("timeout_fired", 32'(locked), 32'd0);
      wait_cyc(3);
      chk("timeout_value_kept", 32'(value), 32'h12);

      // Glitch on the upper phase must only delay capture.
      drive(1'b1, 7'h4F, 2);
      drive(1'b1, 7'h7F, 1);
      drive(1'b1, 7'h4F, 17);
      exp_q.push_back(8'h34);
      drive(1'b0, 7'h66, 20);
      chk("glitch_value", 32'(value), 32'h34);
      chk("glitch_count", 32'(valid_cnt), 32'd2);

      // Short upper phase is abandoned; the following lower capture is orphaned.
      drive(1'b1, 7'h7D, 2);
      drive(1'b0, 7'h07, 20);
      chk("short_no_valid", 32'(valid_cnt), 32'd2);
      chk("short_value_held", 32'(value), 32'h34);
      drive(1'b1, 7'h77, 20);
      exp_q.push_back(8'hAB);
      drive(1'b0, 7'h7C, 20);
      chk("after_short_value", 32'(value), 32'hAB);
      chk("after_short_count", 32'(valid_cnt), 32'd3);

      // Illegal upper glyph.
      e0 = err_cnt;
      drive(1'b1, 7'h00, 20);
`ifdef SEG_CAPTURE_ERR_EN
      drive(1'b0, 7'h3F, 20);
      chk("illegal_err_once", 32'(err_cnt - e0), 32'd1);
      chk("illegal_no_valid", 32'(valid_cnt), 32'd3);
      chk("illegal_value_held", 32'(value), 32'hAB);
`else
      exp_q.push_back(8'h00);
      drive(1'b0, 7'h3F, 20);
      chk("illegal_no_err", 32'(err_cnt - e0), 32'd0);
      chk("illegal_valid", 32'(valid_cnt), 32'd4);
      chk("illegal_value", 32'(value), 32'h00);
`endif

      // Reset while the lower phase is still settling.
      drive(1'b1, 7'h06, 20);
      drive(1'b0, 7'h5B, 4);
      v0 = valid_cnt;
      rst_n = 1'b0;
      #1;
      chk("midrst_value", 32'(value), 32'h00);
      chk("midrst_valid", 32'(valid), 32'd0);
      chk("midrst_locked", 32'(locked), 32'd0);
      chk("midrst_err", 32'(err), 32'd0);
      wait_cyc(3);
      rst_n = 1'b1;
      wait_cyc(20);
      chk("midrst_no_valid", 32'(valid_cnt), 32'(v0));
      chk("midrst_locked_low", 32'(locked), 32'd0);
      drive(1'b1, 7'h77, 20);
      exp_q.push_back(8'hAB);
      drive(1'b0, 7'h7C, 20);
      chk("midrst_new_pair", 32'(value), 32'hAB);
      chk("midrst_new_count", 32'(valid_cnt), 32'(v0 + 1));

      chk("queue_drained", 32'(exp_q.size()), 32'd0);
`ifdef SEG_CAPTURE_ERR_EN
      chk("err_total", 32'(err_cnt), 32'd1);
`else
      chk("err_total", 32'(err_cnt), 32'd0);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/seg_capture.md
SEG_CAPTURE -- requirements
Module: seg_capture

Interface
REQ-001 Parameter STABLE, default 4: consecutive identical synchronized samples required before a digit is captured (range 1..255).
REQ-002 Parameter TIMEOUT, default 1024: cycles without a dsel_in transition before lock is dropped.
REQ-003 Port clk, input, 1: single clock; all state on its rising edge.
REQ-004 Port rst_n, input, 1: asynchronous active-low reset.
REQ-005 Port seg_in, input, 7: multiplexed segment bus; bit6=g ... bit0=a; active-high.
REQ-006 Port dsel_in, input, 1: digit phase; 1 = upper digit on seg_in, 0 = lower digit.
REQ-007 Port value, output, 8: last captured pair {upper nibble, lower nibble}.
REQ-008 Port valid, output, 1: one-cycle pulse when value updates.
REQ-009 Port locked, output, 1: a complete pair has been received and no timeout has occurred since.
REQ-010 Port err, output, 1: one-cycle pulse when a captured pattern is not a legal glyph (REQ-029).

Function
REQ-011 seg_in and dsel_in shall each pass through a 2-flop synchronizer; all further logic shall use only the synchronized copies.
REQ-012 FSM states: WAIT_EDGE, SETTLE, HOLD.
REQ-013 WAIT_EDGE: on a synchronized dsel transition -> SETTLE, latch the new phase, clear the stability counter.
REQ-014 SETTLE: the counter shall increment while seg equals the previous-cycle sample, and shall reset to 0 on any difference.
REQ-015 SETTLE: when the counter reaches STABLE-1 with seg unchanged, capture seg into the phase's digit register, then -> HOLD.
REQ-016 HOLD: ignore seg changes; on a dsel transition -> SETTLE for the new phase.
REQ-017 A dsel transition in SETTLE before capture shall abandon that phase without capturing it, and shall restart SETTLE for the new phase.
REQ-018 Decoding map: 3F=0, 06=1, 5B=2, 4F=3, 66=4, 6D=5, 7D=6, 07=7, 7F=8, 6F=9, 77=A, 7C=b, 39=C, 5E=d, 79=E, 71=F; every other pattern, including 00, is illegal.
REQ-019 A pair completes when a lower-phase capture immediately follows an upper-phase capture, with no abandoned phase between them.
REQ-020 The cycle after a pair completes, value shall update and valid shall pulse for 1 cycle.
REQ-021 Total latency shall be 3 cycles from the capture sample to valid.
REQ-022 locked shall set together with the first valid.
REQ-023 A timeout counter shall clear on each dsel transition and saturate at TIMEOUT.
REQ-024 When the timeout counter reaches TIMEOUT: locked shall clear, the FSM shall return to WAIT_EDGE, and the half-pair pending flag shall clear.
REQ-025 When a timeout and a dsel transition occur in the same cycle, the transition shall win and the timeout shall not fire.
REQ-026 value shall hold between valid pulses; a timeout shall not alter value.

Reset
REQ-027 While rst_n=0, the following shall hold: value=8'h00, valid=0, locked=0, err=0, FSM=WAIT_EDGE, all counters, synchronizers and digit registers 0.
REQ-028 Reset asserted mid-phase shall discard any partial pair; the first pair after release shall require a fresh dsel edge.

Configuration
REQ-029 With SEG_CAPTURE_ERR_EN defined:
- err shall pulse for 1 cycle on capture of an illegal pattern.
- The illegal digit shall not update its register, and that phase shall count as abandoned.
REQ-030 Without SEG_CAPTURE_ERR_EN:
- err shall be tied 0.
- Illegal patterns shall decode to nibble 0 and complete pairs normally.

Verification
REQ-031 Pair capture: reset release, upper 06 for 20 cycles, then lower 5B for 20 cycles (STABLE=4) -> one valid pulse, value=8'h12, locked=1.
REQ-032 Glitch rejection: upper 4F for 20 cycles with a one-cycle 7F glitch at cycle 2, then lower 66 -> value=8'h34; the glitch is never captured.
REQ-033 Short phase: upper 7D for 2 cycles, then lower 07 for 20 cycles -> no valid pulse; the next full upper/lower pair 77/7C gives value=8'hAB.
REQ-034 Timeout (TIMEOUT=64): after a locked pair, hold dsel constant for 70 cycles -> locked falls exactly at the 64th cycle after the last transition; value is unchanged.
REQ-035 Illegal glyph with SEG_CAPTURE_ERR_EN: upper 00, then lower 3F -> err pulses once, no valid; without the macro, value=8'h00 with valid.
REQ-036 Reset mid-operation: assert rst_n=0 during the SETTLE of the lower phase -> all outputs 0 immediately, with no valid pulse after release until a full new pair arrives.
